bram_arbiter: RTL and testbench

Two-requester arbiter and sequencer for the single-port user-project BRAM. Port 0 is the CPU/Wishbone-facing requester and port 1 is the hardware accelerator/DMA requester.
- Grants at most one access per cycle to the BRAM.
- Tracks reads in flight through the fixed BRAM read latency.
- Routes each read response back to the port that issued it.
Sits between the Wishbone decoder / accelerator and the BRAM instance.

---
 rtl/bram_arb_pkg.sv | 27 ++
 rtl/bram_arb_tag_pipe.sv | 27 ++
 rtl/bram_arbiter.sv | 115 +++++++++++
 tb/tb_bram_arbiter.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bram_arb_pkg.sv
// Shared types and constants for the two-port BRAM arbiter.
// Supplies the default for `BRAM_ADDR_LENGTH when the build does not define it.
`ifndef BRAM_ADDR_LENGTH
`define BRAM_ADDR_LENGTH 13
`endif

package bram_arb_pkg;

    typedef logic port_id_t;

    localparam port_id_t PORT_CPU = 1'b0;
    localparam port_id_t PORT_ACC = 1'b1;

    localparam int unsigned LAT_MIN = 1;
    localparam int unsigned LAT_MAX = 16;

    typedef struct packed {
        logic     valid;
        port_id_t port_id;
    } tag_t;

    typedef enum logic {
        PREF0 = 1'b0,
        PREF1 = 1'b1
    } arb_state_e;

endpackage

// File: rtl/bram_arb_tag_pipe.sv
// LATENCY-deep shift register of read tags {valid, port_id}; async active-low clear
// discards every in-flight read.
module bram_arb_tag_pipe
    import bram_arb_pkg::*;
#(
    parameter int unsigned LATENCY = 10
) (
    input  logic CLK,
    input  logic RST_N,
    input  tag_t issue_tag,
    output tag_t resp_tag
);

    tag_t stages [LATENCY];

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int unsigned i = 0; i < LATENCY; i++) stages[i] <= '0;
        end else begin
            stages[0] <= issue_tag;
            for (int unsigned i = 1; i < LATENCY; i++) stages[i] <= stages[i-1];
        end
    end

    assign resp_tag = stages[LATENCY-1];

endmodule

// File: rtl/bram_arbiter.sv
// Two-requester arbiter/sequencer for the single-port BRAM (port 0 = CPU, port 1 = accelerator).
// Define BRAM_ARB_FIXED_PRIO_EN for fixed port-0 priority instead of round-robin.
module bram_arbiter
    import bram_arb_pkg::*;
#(
    parameter int unsigned ADDR_W  = `BRAM_ADDR_LENGTH,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned LATENCY = 10
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              p0_req_valid,
    output logic              p0_req_ready,
    input  logic              p0_req_we,
    input  logic [ADDR_W-1:0] p0_req_addr,
    input  logic [DATA_W-1:0] p0_req_wdata,
    output logic              p0_rsp_valid,
    output logic [DATA_W-1:0] p0_rsp_rdata,
    input  logic              p1_req_valid,
    output logic              p1_req_ready,
    input  logic              p1_req_we,
    input  logic [ADDR_W-1:0] p1_req_addr,
    input  logic [DATA_W-1:0] p1_req_wdata,
    output logic              p1_rsp_valid,
    output logic [DATA_W-1:0] p1_rsp_rdata,
    output logic              bram_en,
    output logic              bram_we,
    output logic [ADDR_W-1:0] bram_a,
    output logic [DATA_W-1:0] bram_di,
    input  logic [DATA_W-1:0] bram_do
);

    if (LATENCY < LAT_MIN || LATENCY > LAT_MAX) begin : g_bad_latency
        $error("bram_arbiter: LATENCY out of range");
    end

    logic              gnt0, gnt1, gnt_any;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    tag_t              issue_tag, resp_tag;

`ifdef BRAM_ARB_FIXED_PRIO_EN
    always_comb begin
        gnt0 = p0_req_valid;
        gnt1 = p1_req_valid & ~p0_req_valid;
    end
`else
    arb_state_e state, state_nxt;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state <= PREF0;
        else        state <= state_nxt;
    end

    // Preferred port wins; the other port takes any cycle the preferred one is idle.
    always_comb begin
        state_nxt = state;
        gnt0      = p0_req_valid & ((state == PREF0) | ~p1_req_valid);
        gnt1      = p1_req_valid & ~gnt0;
        if (gnt0)      state_nxt = PREF1;
        else if (gnt1) state_nxt = PREF0;
    end
`endif

    assign p0_req_ready = gnt0;
    assign p1_req_ready = gnt1;
    assign gnt_any      = gnt0 | gnt1;
    assign sel_we       = gnt1 ? p1_req_we    : p0_req_we;
    assign sel_addr     = gnt1 ? p1_req_addr  : p0_req_addr;
    assign sel_wdata    = gnt1 ? p1_req_wdata : p0_req_wdata;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            bram_en <= 1'b0;
            bram_we <= 1'b0;
            bram_a  <= '0;
            bram_di <= '0;
        end else begin
            bram_en <= gnt_any;
            bram_we <= gnt_any & sel_we;
            if (gnt_any) begin
                bram_a  <= sel_addr;
                bram_di <= sel_wdata;
            end
        end
    end

    assign issue_tag.valid   = gnt_any & ~sel_we;
    assign issue_tag.port_id = gnt1 ? PORT_ACC : PORT_CPU;

    bram_arb_tag_pipe #(
        .LATENCY (LATENCY)
    ) u_tag_pipe (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .issue_tag (issue_tag),
        .resp_tag  (resp_tag)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            p0_rsp_valid <= 1'b0;
            p1_rsp_valid <= 1'b0;
            p0_rsp_rdata <= '0;
            p1_rsp_rdata <= '0;
        end else begin
            p0_rsp_valid <= resp_tag.valid & (resp_tag.port_id == PORT_CPU);
            p1_rsp_valid <= resp_tag.valid & (resp_tag.port_id == PORT_ACC);
            if (resp_tag.valid && resp_tag.port_id == PORT_CPU) p0_rsp_rdata <= bram_do;
            if (resp_tag.valid && resp_tag.port_id == PORT_ACC) p1_rsp_rdata <= bram_do;
        end
    end

endmodule

// File: tb/tb_bram_arbiter.sv
// Scoreboard bench for bram_arbiter with a behavioural BRAM that returns read data
// so that rsp_valid lands LATENCY+1 cycles after acceptance.
`timescale 1ns/1ps
module tb_bram_arbiter;
    localparam int unsigned AW  = 13;
    localparam int unsigned DW  = 32;
    localparam int unsigned LAT = 10;

    logic          CLK = 1'b0;
    logic          RST_N = 1'b0;
    logic          p0_req_valid = 1'b0, p0_req_ready, p0_req_we = 1'b0;
    logic [AW-1:0] p0_req_addr = '0;
    logic [DW-1:0] p0_req_wdata = '0;
    logic          p0_rsp_valid;
    logic [DW-1:0] p0_rsp_rdata;
    logic          p1_req_valid = 1'b0, p1_req_ready, p1_req_we = 1'b0;
    logic [AW-1:0] p1_req_addr = '0;
    logic [DW-1:0] p1_req_wdata = '0;
    logic          p1_rsp_valid;
    logic [DW-1:0] p1_rsp_rdata;
    logic          bram_en, bram_we;
    logic [AW-1:0] bram_a;
    logic [DW-1:0] bram_di, bram_do;

    always #5 CLK = ~CLK;

    bram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LATENCY(LAT)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready), .p0_req_we(p0_req_we),
        .p0_req_addr(p0_req_addr), .p0_req_wdata(p0_req_wdata),
        .p0_rsp_valid(p0_rsp_valid), .p0_rsp_rdata(p0_rsp_rdata),
        .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready), .p1_req_we(p1_req_we),
        .p1_req_addr(p1_req_addr), .p1_req_wdata(p1_req_wdata),
        .p1_rsp_valid(p1_rsp_valid), .p1_rsp_rdata(p1_rsp_rdata),
        .bram_en(bram_en), .bram_we(bram_we), .bram_a(bram_a), .bram_di(bram_di),
        .bram_do(bram_do)
    );

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } req_t;

    typedef struct {
        logic          port;
        logic [DW-1:0] data;
        int unsigned   cyc;
    } sb_t;

    req_t q0[$], q1[$];
    sb_t  sb_q[$];
    int unsigned n_cmp = 0, n_err = 0;
    int unsigned cyc = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] init_pat(input logic [AW-1:0] a);
        if (a == 13'h005) return 32'hDEADBEEF;
        return ({19'd0, a} * 32'h9E3779B1) ^ 32'hA5A5_0000;
    endfunction

    // Behavioural BRAM: read data valid LATENCY-1 cycles after the bram_en cycle.
    logic [DW-1:0] mem [int unsigned];
    logic [DW-1:0] rpipe [LAT-1];
    assign bram_do = rpipe[LAT-2];

    always @(posedge CLK) begin
        rpipe[0] <= (bram_en && !bram_we) ?
                    (mem.exists(bram_a) ? mem[bram_a] : init_pat(bram_a)) : '0;
        for (int i = 1; i < LAT - 1; i++) rpipe[i] <= rpipe[i-1];
        if (bram_en && bram_we) mem[bram_a] = bram_di;
    end

    always @(posedge CLK) cyc <= cyc + 1;

    // Reference model state
    logic [DW-1:0] shadow [int unsigned];
    logic          mg0 = 1'b0, mg1 = 1'b0, mpref;
    req_t          mreq;
    logic          exp_en, exp_we;
    logic [AW-1:0] exp_a;
    logic [DW-1:0] exp_di;
    logic [DW-1:0] last0 = '0, last1 = '0;

    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            mpref  <= 1'b0;
            exp_en <= 1'b0;
            exp_we <= 1'b0;
        end else begin
            exp_en <= mg0 | mg1;
            exp_we <= (mg0 | mg1) & mreq.we;
            if (mg0 | mg1) begin
                exp_a  <= mreq.addr;
                exp_di <= mreq.wdata;
            end
            if (mg0)      mpref <= 1'b1;
            else if (mg1) mpref <= 1'b0;
        end
    end

    task automatic take_rsp(input logic port, input logic [DW-1:0] got);
        sb_t e;
        if (sb_q.size() == 0) begin
            chk("rsp_unexpected", {63'd0, port}, 64'hFFFF);
            return;
        end
        e = sb_q.pop_front();
        chk("rsp_port", {63'd0, port}, {63'd0, e.port});
        chk("rsp_data", {32'd0, got}, {32'd0, e.data});
        chk("rsp_latency", cyc - e.cyc, LAT + 1);
        if (port) last1 = e.data;
        else      last0 = e.data;
    endtask

    always @(negedge CLK) begin
        if (!RST_N) begin
            mg0 = 1'b0;
            mg1 = 1'b0;
            last0 = '0;
            last1 = '0;
            chk("rst_ready0", {63'd0, p0_req_ready}, 0);
            chk("rst_ready1", {63'd0, p1_req_ready}, 0);
            chk("rst_bram_en", {63'd0, bram_en}, 0);
            chk("rst_bram_we", {63'd0, bram_we}, 0);
            chk("rst_bram_a", {51'd0, bram_a}, 0);
            chk("rst_rsp_valid", {62'd0, p1_rsp_valid, p0_rsp_valid}, 0);
            chk("rst_rdata", {p1_rsp_rdata, p0_rsp_rdata}, 0);
        end else begin
`ifdef BRAM_ARB_FIXED_PRIO_EN
            mg0 = p0_req_valid;
            mg1 = p1_req_valid && !p0_req_valid;
`else
            mg0 = p0_req_valid && (!mpref || !p1_req_valid);
            mg1 = p1_req_valid && !mg0;
`endif
            chk("ready0", {63'd0, p0_req_ready}, {63'd0, mg0});
            chk("ready1", {63'd0, p1_req_ready}, {63'd0, mg1});
            chk("bram_en", {63'd0, bram_en}, {63'd0, exp_en});
            chk("bram_we", {63'd0, bram_we}, {63'd0, exp_we});
            if (exp_en) chk("bram_a", {51'd0, bram_a}, {51'd0, exp_a});
            if (exp_we) chk("bram_di", {32'd0, bram_di}, {32'd0, exp_di});
            if (p0_rsp_valid && p1_rsp_valid) chk("rsp_both", 1, 0);
            if (p0_rsp_valid) take_rsp(1'b0, p0_rsp_rdata);
            if (p1_rsp_valid) take_rsp(1'b1, p1_rsp_rdata);
            chk("rdata0", {32'd0, p0_rsp_rdata}, {32'd0, last0});
            chk("rdata1", {32'd0, p1_rsp_rdata}, {32'd0, last1});
            if (mg0 || mg1) begin
                mreq = mg1 ? q1[0] : q0[0];
                if (mreq.we) shadow[mreq.addr] = mreq.wdata;
                else sb_q.push_back('{port: mg1, cyc: cyc,
                    data: shadow.exists(mreq.addr) ? shadow[mreq.addr] : init_pat(mreq.addr)});
            end
        end
    end

    // Requester drivers: hold the queue head until the model grant retires it.
    initial begin
        forever begin
            @(posedge CLK);
            #1;
            if (RST_N) begin
                if (mg0 && q0.size() > 0) void'(q0.pop_front());
                if (mg1 && q1.size() > 0) void'(q1.pop_front());
            end
            p0_req_valid = RST_N && q0.size() > 0;
            p1_req_valid = RST_N && q1.size() > 0;
            if (q0.size() > 0) {p0_req_we, p0_req_addr, p0_req_wdata} = {q0[0].we, q0[0].addr, q0[0].wdata};
            if (q1.size() > 0) {p1_req_we, p1_req_addr, p1_req_wdata} = {q1[0].we, q1[0].addr, q1[0].wdata};
        end
    end

    task automatic wait_idle(input int unsigned max_cyc);
        int unsigned n = 0;
        while ((q0.size() || q1.size() || sb_q.size()) && n < max_cyc) begin
            @(posedge CLK);
            n++;
        end
        chk("drain", {63'd0, (q0.size() == 0 && q1.size() == 0 && sb_q.size() == 0)}, 1);
        repeat (3) @(posedge CLK);
    endtask

    function automatic req_t rd(input logic [AW-1:0] a);
        return '{we: 1'b0, addr: a, wdata: '0};
    endfunction

    initial begin
        int unsigned k;
        logic [31:0] r;
        repeat (3) @(posedge CLK);
        #2 RST_N = 1'b1;

        q0.push_back(rd(13'h005));
        wait_idle(100);

        for (int i = 0; i < 4; i++) begin
            q0.push_back(rd(AW'(16 + i)));
            q1.push_back(rd(AW'(32 + i)));
        end
        wait_idle(100);

        for (int i = 0; i < 16; i++) q0.push_back(rd(AW'(i)));
        wait_idle(100);

        q1.push_back('{we: 1'b1, addr: 13'h1FFF, wdata: 32'h12345678});
        q1.push_back(rd(13'h1FFF));
        wait_idle(100);

        for (int i = 0; i < 5; i++) q0.push_back(rd(AW'(64 + i)));
        for (int i = 0; i < 2; i++) q1.push_back(rd(AW'(80 + i)));
        wait_idle(100);

        for (int i = 0; i < 40; i++) begin
            r = $urandom;
            if (r[1]) q0.push_back('{we: r[0], addr: AW'($urandom_range(0, 15)), wdata: $urandom});
            else      q1.push_back('{we: r[0], addr: AW'($urandom_range(0, 15)), wdata: $urandom});
        end
        wait_idle(200);

        for (int i = 0; i < 3; i++) q0.push_back(rd(AW'(100 + i)));
        k = 0;
        while (!mg0 && k < 20) begin
            @(negedge CLK);
            #1;
            k++;
        end
        chk("first_accept", {63'd0, mg0}, 1);
        repeat (4) @(posedge CLK);
        #2 RST_N = 1'b0;
        q0.delete();
        q1.delete();
        sb_q.delete();
        p0_req_valid = 1'b0;
        p1_req_valid = 1'b0;
        repeat (3) @(posedge CLK);
        #2 RST_N = 1'b1;
        repeat (20) @(posedge CLK);
        chk("post_reset_idle", sb_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
